// File: rtl/puf_pkg.sv
// Shared state encoding and default sizes for the ring-oscillator PUF response reader.
// Feature switch PUF_MAJ_VOTE_EN adds the per-bit vote count.
package puf_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        SETTLE,
        COMPARE,
        DONE
    } puf_state_e;

    localparam int CHAL_W_DEF    = 5;
    localparam int CNT_W_DEF     = 32;
    localparam int RESP_BITS_DEF = 8;

`ifdef PUF_MAJ_VOTE_EN
    localparam int VOTES = 3;
`endif

endpackage

// File: rtl/puf_phase_timer.sv
// Loadable down-counter timing one measurement phase; a phase of N cycles is loaded with N-1.
// done_o is high while the count sits at zero; load_i takes priority over counting.
module puf_phase_timer #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/puf_resp_reader.sv
// PUF measurement sequencer: clear/run/settle/compare per bit, RESP_BITS*T+1 cycles to resp_valid
// (3x per bit when PUF_MAJ_VOTE_EN is defined); resp is held under valid/ready until accepted.
module puf_resp_reader
    import puf_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int CHAL_W     = CHAL_W_DEF,
    parameter int RESP_BITS  = RESP_BITS_DEF,
    parameter int WIN_CYC    = 1024,
    parameter int SETTLE_CYC = 4,
    parameter int CLR_CYC    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [CHAL_W-1:0]    chal_a_base,
    input  logic [CHAL_W-1:0]    chal_b_base,
    input  logic [CNT_W-1:0]     count_a,
    input  logic [CNT_W-1:0]     count_b,
    output logic                 osc_en,
    output logic                 cnt_clr,
    output logic [CHAL_W-1:0]    chal_a,
    output logic [CHAL_W-1:0]    chal_b,
    output logic                 busy,
    output logic [RESP_BITS-1:0] resp,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic                 tie
);

    localparam int MAX_CYC = (WIN_CYC > CLR_CYC)
                           ? ((WIN_CYC > SETTLE_CYC) ? WIN_CYC : SETTLE_CYC)
                           : ((CLR_CYC > SETTLE_CYC) ? CLR_CYC : SETTLE_CYC);
    localparam int TMR_W = $clog2(MAX_CYC + 1);
    localparam int IDX_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

    localparam logic [TMR_W-1:0] CLR_LD   = TMR_W'(CLR_CYC - 1);
    localparam logic [TMR_W-1:0] WIN_LD   = TMR_W'(WIN_CYC - 1);
    localparam logic [TMR_W-1:0] SET_LD   = TMR_W'(SETTLE_CYC - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RESP_BITS - 1);

    puf_state_e           state_q, state_d;
    logic [IDX_W-1:0]     bit_q, bit_d;
    logic [CHAL_W-1:0]    base_a_q, base_a_d, base_b_q, base_b_d;
    logic [CHAL_W-1:0]    chal_a_q, chal_a_d, chal_b_q, chal_b_d;
    logic [RESP_BITS-1:0] resp_q, resp_d;
    logic                 busy_q, busy_d, resp_valid_q, resp_valid_d, tie_q, tie_d;
    logic                 osc_en_q, cnt_clr_q;
    logic                 tmr_load, tmr_done;
    logic [TMR_W-1:0]     tmr_ld_val;
    logic                 gt, eq, last_meas, meas_bit;

    assign gt = (count_a > count_b);
    assign eq = (count_a == count_b);

`ifdef PUF_MAJ_VOTE_EN
    // Same challenge pair is measured VOTES times; the bit is the majority of the outcomes.
    logic [1:0] vote_q, vote_d, ones_q, ones_d;

    assign last_meas = (vote_q == 2'(VOTES - 1));
    assign meas_bit  = ((ones_q + {1'b0, gt}) >= 2'd2);

    always_comb begin
        vote_d = vote_q;
        ones_d = ones_q;
        if (state_q == COMPARE) begin
            if (last_meas) begin
                vote_d = '0;
                ones_d = '0;
            end else begin
                vote_d = vote_q + 2'd1;
                ones_d = ones_q + {1'b0, gt};
            end
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            vote_q <= '0;
            ones_q <= '0;
        end else begin
            vote_q <= vote_d;
            ones_q <= ones_d;
        end
    end
`else
    assign last_meas = 1'b1;
    assign meas_bit  = gt;
`endif

    always_comb begin
        state_d      = state_q;
        bit_d        = bit_q;
        base_a_d     = base_a_q;
        base_b_d     = base_b_q;
        resp_d       = resp_q;
        busy_d       = busy_q;
        resp_valid_d = resp_valid_q;
        tie_d        = tie_q;
        tmr_load     = 1'b0;
        tmr_ld_val   = CLR_LD;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = CLEAR;
                    base_a_d = chal_a_base;
                    base_b_d = chal_b_base;
                    bit_d    = '0;
                    resp_d   = '0;
                    tie_d    = 1'b0;
                    busy_d   = 1'b1;
                    tmr_load = 1'b1;
                end
            end
            CLEAR: begin
                if (tmr_done) begin
                    state_d    = RUN;
                    tmr_load   = 1'b1;
                    tmr_ld_val = WIN_LD;
                end
            end
            RUN: begin
                if (tmr_done) begin
                    state_d    = SETTLE;
                    tmr_load   = 1'b1;
                    tmr_ld_val = SET_LD;
                end
            end
            SETTLE: begin
                if (tmr_done) begin
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                tie_d    = tie_q | eq;
                state_d  = CLEAR;
                tmr_load = 1'b1;
                if (last_meas) begin
                    resp_d[bit_q] = meas_bit;
                    if (bit_q == LAST_IDX) begin
                        state_d  = DONE;
                        tmr_load = 1'b0;
                    end else begin
                        bit_d = bit_q + IDX_W'(1);
                    end
                end
            end
            DONE: begin
                resp_valid_d = 1'b1;
                if (resp_valid_q && resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                    busy_d       = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Challenges only move on entry to CLEAR, so they are frozen while the oscillators run.
        chal_a_d = chal_a_q;
        chal_b_d = chal_b_q;
        if (state_d == CLEAR) begin
            chal_a_d = base_a_d + CHAL_W'(bit_d);
            chal_b_d = base_b_d + CHAL_W'(bit_d);
        end
    end

    puf_phase_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_ld_val),
        .done_o     (tmr_done)
    );

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q      <= IDLE;
            bit_q        <= '0;
            base_a_q     <= '0;
            base_b_q     <= '0;
            chal_a_q     <= '0;
            chal_b_q     <= '0;
            resp_q       <= '0;
            busy_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            tie_q        <= 1'b0;
            osc_en_q     <= 1'b0;
            cnt_clr_q    <= 1'b1;
        end else begin
            state_q      <= state_d;
            bit_q        <= bit_d;
            base_a_q     <= base_a_d;
            base_b_q     <= base_b_d;
            chal_a_q     <= chal_a_d;
            chal_b_q     <= chal_b_d;
            resp_q       <= resp_d;
            busy_q       <= busy_d;
            resp_valid_q <= resp_valid_d;
            tie_q        <= tie_d;
            osc_en_q     <= (state_d == RUN);
            cnt_clr_q    <= (state_d == CLEAR);
        end
    end

    assign osc_en     = osc_en_q;
    assign cnt_clr    = cnt_clr_q;
    assign chal_a     = chal_a_q;
    assign chal_b     = chal_b_q;
    assign busy       = busy_q;
    assign resp       = resp_q;
    assign resp_valid = resp_valid_q;
    assign tie        = tie_q;

endmodule

// File: tb/tb_puf_resp_reader.sv
// Bench for puf_resp_reader: emulates the two bank counters and scores each word against a model.
`timescale 1ns/1ps
module tb_puf_resp_reader;

    localparam int CNT_W = 32, CHAL_W = 5, RB = 8, WIN = 1024, SETC = 4, CLRC = 2;
    localparam int T = CLRC + WIN + SETC + 1;
`ifdef PUF_MAJ_VOTE_EN
    localparam int V = 3;
`else
    localparam int V = 1;
`endif
    localparam int NMEAS = RB * V;
    localparam int NREC  = 512;

    logic              clk = 1'b0, rst_n = 1'b0, start = 1'b0, resp_ready = 1'b0;
    logic [CHAL_W-1:0] chal_a_base = '0, chal_b_base = '0;
    logic [CNT_W-1:0]  count_a = '0, count_b = '0;
    logic              osc_en, cnt_clr, busy, resp_valid, tie;
    logic [CHAL_W-1:0] chal_a, chal_b;
    logic [RB-1:0]     resp;

    puf_resp_reader #(
        .CNT_W(CNT_W), .CHAL_W(CHAL_W), .RESP_BITS(RB),
        .WIN_CYC(WIN), .SETTLE_CYC(SETC), .CLR_CYC(CLRC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .chal_a_base(chal_a_base), .chal_b_base(chal_b_base),
        .count_a(count_a), .count_b(count_b),
        .osc_en(osc_en), .cnt_clr(cnt_clr), .chal_a(chal_a), .chal_b(chal_b),
        .busy(busy), .resp(resp), .resp_valid(resp_valid), .resp_ready(resp_ready), .tie(tie)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Counter emulation: counts read zero after a clear and take the table value once osc_en drops.
    logic [CNT_W-1:0]  mca [NMEAS];
    logic [CNT_W-1:0]  mcb [NMEAS];
    logic [CHAL_W-1:0] rec_a [NREC];
    logic [CHAL_W-1:0] rec_b [NREC];
    int                rec_run [NREC];
    logic              rec_bad [NREC];
    int                meas_cnt = 0, word_base = 0, cur_m = 0;
    logic              prev_clr = 1'b1, prev_osc = 1'b0;

    always @(negedge clk) begin
        if (cnt_clr && !prev_clr) begin
            cur_m = meas_cnt - word_base;
            if (meas_cnt < NREC) begin
                rec_a[meas_cnt]   = chal_a;
                rec_b[meas_cnt]   = chal_b;
                rec_run[meas_cnt] = 0;
                rec_bad[meas_cnt] = 1'b0;
            end
            meas_cnt++;
            count_a = '0;
            count_b = '0;
        end
        if (osc_en && meas_cnt > 0 && meas_cnt <= NREC) begin
            rec_run[meas_cnt-1] = rec_run[meas_cnt-1] + 1;
            if (chal_a != rec_a[meas_cnt-1] || chal_b != rec_b[meas_cnt-1])
                rec_bad[meas_cnt-1] = 1'b1;
        end
        if (!osc_en && prev_osc && cur_m >= 0 && cur_m < NMEAS) begin
            count_a = mca[cur_m];
            count_b = mcb[cur_m];
        end
        prev_clr = cnt_clr;
        prev_osc = osc_en;
    end

    // Reference: bit b is the majority over its V measurements of (a > b); any equality sets tie.
    task automatic model(output logic [RB-1:0] r, output logic t);
        r = '0;
        t = 1'b0;
        for (int b = 0; b < RB; b++) begin
            int ones = 0;
            for (int v = 0; v < V; v++) begin
                if (mca[b*V+v] > mcb[b*V+v]) ones++;
                if (mca[b*V+v] == mcb[b*V+v]) t = 1'b1;
            end
            r[b] = (2 * ones > V);
        end
    endtask

    task automatic run_word(input string nm, input logic [CHAL_W-1:0] ba, input logic [CHAL_W-1:0] bb,
                            input logic [RB-1:0] exp_resp, input logic exp_tie,
                            input int hold, input logic rdy_early);
        int lat = 0;
        int base;
        @(negedge clk);
        base = meas_cnt;
        word_base = meas_cnt;
        chal_a_base = ba;
        chal_b_base = bb;
        resp_ready = rdy_early;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chal_a_base = ~ba;
        chal_b_base = ~bb;
        chk({nm, "_busy_set"}, busy, 1);
        chk({nm, "_tie_cleared"}, tie, 0);
        chk({nm, "_resp_cleared"}, resp, 0);
        for (int c = 1; c <= NMEAS * T + 50; c++) begin
            @(negedge clk);
            start = (c == 100);
            if (resp_valid) begin
                lat = c;
                break;
            end
        end
        start = 1'b0;
        chk({nm, "_latency"}, lat, NMEAS * T + 1);
        chk({nm, "_resp"}, resp, exp_resp);
        chk({nm, "_tie"}, tie, exp_tie);
        chk({nm, "_meas_count"}, meas_cnt - base, NMEAS);
        for (int m = 0; m < NMEAS; m++) begin
            logic [CHAL_W-1:0] ea, eb;
            ea = ba + CHAL_W'(m / V);
            eb = bb + CHAL_W'(m / V);
            chk($sformatf("%s_chal_a_m%0d", nm, m), rec_a[base+m], ea);
            chk($sformatf("%s_chal_b_m%0d", nm, m), rec_b[base+m], eb);
            chk($sformatf("%s_run_len_m%0d", nm, m), rec_run[base+m], WIN);
            chk($sformatf("%s_chal_moved_m%0d", nm, m), rec_bad[base+m], 0);
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            start = (h == 5);
            chk($sformatf("%s_hold_resp_%0d", nm, h), resp, exp_resp);
            chk($sformatf("%s_hold_valid_%0d", nm, h), resp_valid, 1);
            chk($sformatf("%s_hold_busy_%0d", nm, h), busy, 1);
        end
        start = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk({nm, "_valid_dropped"}, resp_valid, 0);
        chk({nm, "_busy_dropped"}, busy, 0);
        @(negedge clk);
        chk({nm, "_stays_idle"}, busy, 0);
    endtask

    typedef struct {
        logic [CHAL_W-1:0]         ba, bb;
        logic [RB-1:0][CNT_W-1:0]  ca, cb;
        logic [RB-1:0]             er;
        logic                      et;
        int                        hold;
    } vec_t;

    vec_t vecs [4];

    task automatic load_vec(input int k);
        for (int m = 0; m < NMEAS; m++) begin
            mca[m] = vecs[k].ca[m / V];
            mcb[m] = vecs[k].cb[m / V];
        end
    endtask

    task automatic random_word(input string nm, input int hold, input logic rdy_early);
        logic [RB-1:0] er;
        logic et;
        for (int m = 0; m < NMEAS; m++) begin
            int sel = $urandom_range(0, 3);
            mca[m] = $urandom;
            mcb[m] = (sel == 0) ? mca[m] : (sel == 1) ? (mca[m] ^ 32'h8000_0000) : $urandom;
        end
        model(er, et);
        run_word(nm, CHAL_W'($urandom), CHAL_W'($urandom), er, et, hold, rdy_early);
    endtask

    task automatic reset_mid();
        int base;
        logic found = 1'b0;
        load_vec(2);
        @(negedge clk);
        base = meas_cnt;
        word_base = meas_cnt;
        chal_a_base = 5'd9;
        chal_b_base = 5'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 5 * V * T + 100; c++) begin
            @(negedge clk);
            if ((meas_cnt - base) == 3 * V + 1 && osc_en) begin
                found = 1'b1;
                break;
            end
        end
        chk("rst_reached_bit3_run", found, 1);
        repeat (10) @(negedge clk);
        chk("rst_pre_osc_en", osc_en, 1);
        chk("rst_pre_tie_sticky", tie, 1);
        #2 rst_n = 1'b1;
        #1;
        chk("rst_async_osc_en", osc_en, 0);
        chk("rst_async_cnt_clr", cnt_clr, 1);
        chk("rst_async_resp", resp, 0);
        chk("rst_async_busy", busy, 0);
        chk("rst_async_tie", tie, 0);
        chk("rst_async_chal_a", chal_a, 0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_release_idle", cnt_clr, 0);
    endtask

    initial begin
        logic [RB-1:0] er;
        logic et;

        for (int i = 0; i < RB; i++) begin
            vecs[0].ca[i] = 32'd500;
            vecs[0].cb[i] = 32'd400;
            vecs[1].ca[i] = 32'(i * 100);
            vecs[1].cb[i] = 32'd300;
            vecs[2].ca[i] = (i == 0) ? 32'd600 : (i == 1) ? 32'd450 : (i == 2) ? 32'd700 : 32'd100;
            vecs[2].cb[i] = (i == 0) ? 32'd500 : (i == 1) ? 32'd450 : (i == 2) ? 32'd100 : 32'd200;
            vecs[3].ca[i] = (i % 2 == 0) ? 32'h8000_0000 : 32'h0000_0005;
            vecs[3].cb[i] = (i % 2 == 0) ? 32'h7FFF_FFFF : 32'h8000_0004;
        end
        vecs[0].ba = 5'd0;  vecs[0].bb = 5'd16; vecs[0].er = 8'hFF; vecs[0].et = 1'b0; vecs[0].hold = 0;
        vecs[1].ba = 5'd30; vecs[1].bb = 5'd31; vecs[1].er = 8'hF0; vecs[1].et = 1'b1; vecs[1].hold = 20;
        vecs[2].ba = 5'd3;  vecs[2].bb = 5'd7;  vecs[2].er = 8'h05; vecs[2].et = 1'b1; vecs[2].hold = 0;
        vecs[3].ba = 5'd12; vecs[3].bb = 5'd20; vecs[3].er = 8'h55; vecs[3].et = 1'b0; vecs[3].hold = 2;

        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_osc_en", osc_en, 0);
        chk("reset_cnt_clr", cnt_clr, 1);
        chk("reset_chal_a", chal_a, 0);
        chk("reset_chal_b", chal_b, 0);
        chk("reset_busy", busy, 0);
        chk("reset_resp", resp, 0);
        chk("reset_resp_valid", resp_valid, 0);
        chk("reset_tie", tie, 0);
        rst_n = 1'b0;
        resp_ready = 1'b1;
        repeat (2) @(negedge clk);
        resp_ready = 1'b0;
        chk("idle_cnt_clr_low", cnt_clr, 0);
        chk("idle_ready_ignored", busy, 0);

`ifdef PUF_MAJ_VOTE_EN
        load_vec(0);
        run_word("vec0", vecs[0].ba, vecs[0].bb, vecs[0].er, vecs[0].et, vecs[0].hold, 1'b0);
        reset_mid();
        for (int m = 0; m < NMEAS; m++) begin
            mca[m] = $urandom_range(0, 1000);
            mcb[m] = $urandom_range(0, 1000);
        end
        mca[0] = 32'd900; mcb[0] = 32'd100;
        mca[1] = 32'd100; mcb[1] = 32'd900;
        mca[2] = 32'd900; mcb[2] = 32'd100;
        model(er, et);
        run_word("vote", 5'd4, 5'd29, er, et, 3, 1'b0);
        chk("vote_bit0_majority", resp_valid === 1'b0 ? er[0] : 1'b0, 1);
`else
        for (int k = 0; k < 4; k++) begin
            load_vec(k);
            run_word($sformatf("vec%0d", k), vecs[k].ba, vecs[k].bb, vecs[k].er, vecs[k].et,
                     vecs[k].hold, 1'b0);
        end
        reset_mid();
        random_word("rand0", 0, 1'b1);
        random_word("rand1", 3, 1'b0);
        random_word("rand2", 0, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/puf_resp_reader.md
Name: puf_resp_reader

Overview:
- Measurement controller and response reader for the ring-oscillator PUF datapath.
- Drives the two oscillator-bank challenge selects, enable, and counter-clear signals.
- Times a fixed measurement window on the system clock, then samples and compares the two bank counts.
- Packs one response bit per comparison into a RESP_BITS word and presents it with a valid/ready handshake.

Parameters:
- CNT_W, 32: width of each bank count input.
- CHAL_W, 5: width of each bank challenge select (32 oscillators per bank).
- RESP_BITS, 8: response bits per request.
- WIN_CYC, 1024: clk cycles oscillators run per measurement (min 1).
- SETTLE_CYC, 4: clk cycles after disable before counts are sampled (min 2; lets the async counters settle).
- CLR_CYC, 2: clk cycles counter clear is held (min 1).

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: reset, asynchronous, active-high.
- start, input, 1: request pulse; accepted only in IDLE.
- chal_a_base, input, CHAL_W: bank A challenge for bit 0.
- chal_b_base, input, CHAL_W: bank B challenge for bit 0.
- count_a, input, CNT_W: bank A counter value; stable whenever osc_en=0.
- count_b, input, CNT_W: bank B counter value.
- osc_en, output, 1: oscillator enable to both banks.
- cnt_clr, output, 1: clear to both bank counters.
- chal_a, output, CHAL_W: bank A mux select.
- chal_b, output, CHAL_W: bank B mux select.
- busy, output, 1: high from start acceptance until the response handshake completes.
- resp, output, RESP_BITS: response word, bit i = result of measurement i.
- resp_valid, output, 1: response available.
- resp_ready, input, 1: consumer accepts resp.
- tie, output, 1: sticky; set if any comparison in the current word had count_a == count_b.

Behaviour:
- Reset values: osc_en=0, cnt_clr=1, chal_a=0, chal_b=0, busy=0, resp=0, resp_valid=0, tie=0. State is IDLE and bit index is 0.
- IDLE:
  - cnt_clr=0.
  - When start=1, capture both bases into registers, set bit index i=0, clear resp and tie, set busy=1, and go to CLEAR.
- CLEAR:
  - chal_a = base_a + i and chal_b = base_b + i, both mod 2^CHAL_W (wrap-around).
  - cnt_clr=1 for CLR_CYC cycles, osc_en=0, then go to RUN.
- RUN: cnt_clr=0, osc_en=1 for exactly WIN_CYC cycles, then go to SETTLE.
- SETTLE: osc_en=0 for SETTLE_CYC cycles, then go to COMPARE.
- COMPARE (1 cycle):
  - Set bit i = (count_a > count_b), unsigned compare over the full CNT_W.
  - If the counts are equal, bit i = 0 and tie is set.
  - If i == RESP_BITS-1, go to DONE; otherwise increment i and go to CLEAR.
- DONE:
  - resp_valid=1 and resp is held stable until resp_ready=1 is sampled.
  - On that cycle, go to IDLE and drop resp_valid and busy on the next edge.
- Timing: per-bit time T = CLR_CYC + WIN_CYC + SETTLE_CYC + 1. resp_valid rises RESP_BITS*T + 1 cycles after the start edge (default 8*1031+1 = 8249).
- challenges change only in CLEAR; they never change while osc_en=1.
- start while busy is ignored; base inputs are not re-sampled.
- resp_ready outside DONE is ignored.
- Reset asserted mid-operation:
  - osc_en drops immediately (asynchronous) and all outputs take their reset values.
  - The partial response is discarded.

Optional Feature:
- Macro: PUF_MAJ_VOTE_EN.
- Defined:
  - Each bit is measured 3 times with the same challenge pair (CLEAR/RUN/SETTLE/COMPARE repeated).
  - Bit value = majority of the 3 outcomes. tie is set if any of the 3 outcomes tied.
  - Latency becomes 3*RESP_BITS*T + 1.
- Undefined: single measurement per bit, as described above.

Decomposition:
- puf_pkg:
  - State enum: IDLE, CLEAR, RUN, SETTLE, COMPARE, DONE.
  - Default constants for CHAL_W, CNT_W, and RESP_BITS.
  - Vote count constant (3).
- Sub-module puf_phase_timer: loadable down-counter with load value and done pulse. One instance times the CLEAR, RUN, and SETTLE phases.

Test Plan:
The bench models the counters directly.
- Basic compare:
  - Stimulus: reset; start with bases 0/16; count_a=500, count_b=400 for every bit.
  - Response: resp=0xFF, tie=0, resp_valid at cycle 8249.
- Wrap-around challenges:
  - Stimulus: bases 30/31; capture chal_a/chal_b in each CLEAR phase.
  - Response: chal_a sequence 30,31,0,1,…,5; chal_b sequence 31,0,1,…,6.
- Ties and mixed bits:
  - Stimulus: per-bit counts make bits 0,2 have a>b, bit 1 equal, others a<b.
  - Response: resp=0x05, tie=1.
- Handshake hold:
  - Stimulus: hold resp_ready=0 for 20 cycles after resp_valid; pulse start during that time.
  - Response: resp stable, busy=1, start ignored; IDLE one cycle after ready.
- Mid-operation reset:
  - Stimulus: assert rst_n during RUN of bit 3.
  - Response: osc_en=0 same cycle, resp=0; a new start produces a full 8-bit measurement.
- PUF_MAJ_VOTE_EN:
  - Stimulus: bit 0 outcomes a>b, a<b, a>b.
  - Response: bit 0 = 1, resp_valid at 3*8*1031+1.
